// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package inst_fetch_pkg;

    localparam int          FETCH_ADDR_W = 8;
    localparam int          FETCH_INST_W = 12;
    localparam int          CNT_INST_MAX = 256;
    localparam logic [11:0] HALT_ENC     = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FIN   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_issue_reg.sv
// One-entry valid/ready holding register for the issued instruction and its PC.
module inst_issue_reg
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic [INST_W-1:0] load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              ready,
    output logic              valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
);

    logic              valid_r;
    logic [INST_W-1:0] inst_r;
    logic [ADDR_W-1:0] pc_r;

    // Flush drops the entry; a load may replace an entry in its handshake cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            inst_r  <= {INST_W{1'b0}};
            pc_r    <= {ADDR_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            inst_r  <= load_inst;
            pc_r    <= load_pc;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid    = valid_r;
    assign inst_out = inst_r;
    assign inst_pc  = pc_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: reads instruction memory in address order and
// issues words over valid/ready until HALT, end of memory, or abort.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W    = FETCH_ADDR_W,
    parameter int                INST_W    = FETCH_INST_W,
    parameter int                DEPTH     = CNT_INST_MAX,
    parameter logic [INST_W-1:0] HALT_INST = INST_W'(HALT_ENC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PC_ONE  = (ADDR_W+1)'(1);

    fetch_state_e    state_r, state_nxt_s;
    logic [ADDR_W:0] pc_r, pc_nxt_s;
    logic            end_flag_r, end_flag_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic            mem_en_s, load_s, flush_s;
    logic            inst_valid_s, handshake_s, halt_s, last_s;

    assign halt_s      = (mem_inst == HALT_INST);
    assign last_s      = (pc_r == LAST_PC);
    assign handshake_s = inst_valid_s && inst_ready && !stop && !rst;

    // Next-state, PC and read-enable logic; stop drops everything with no done.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        end_flag_nxt_s = end_flag_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        mem_en_s       = 1'b0;
        load_s         = 1'b0;
        flush_s        = 1'b0;
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else if (stop) begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
            flush_s     = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pc_nxt_s    = {(ADDR_W+1){1'b0}};
                        busy_nxt_s  = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    mem_en_s = 1'b1;
                    if (halt_s) begin
                        state_nxt_s = ST_FIN;
                        done_nxt_s  = 1'b1;
                    end else begin
                        load_s         = 1'b1;
                        pc_nxt_s       = pc_r + PC_ONE;
                        end_flag_nxt_s = last_s;
                        state_nxt_s    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!handshake_s) begin
                        state_nxt_s = ST_ISSUE;
                    end else if (end_flag_r) begin
                        state_nxt_s = ST_FIN;
                        done_nxt_s  = 1'b1;
                    end else begin
                        // Refill the holding register in the handshake cycle.
                        mem_en_s = 1'b1;
                        if (halt_s) begin
                            state_nxt_s = ST_FIN;
                            done_nxt_s  = 1'b1;
                        end else begin
                            load_s         = 1'b1;
                            pc_nxt_s       = pc_r + PC_ONE;
                            end_flag_nxt_s = last_s;
                            state_nxt_s    = ST_ISSUE;
                        end
                    end
                end
                ST_FIN: begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, PC and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= {(ADDR_W+1){1'b0}};
            end_flag_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            end_flag_r <= end_flag_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    inst_issue_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_issue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_s),
        .load      (load_s),
        .load_inst (mem_inst),
        .load_pc   (pc_r[ADDR_W-1:0]),
        .ready     (inst_ready),
        .valid     (inst_valid_s),
        .inst_out  (inst_out),
        .inst_pc   (inst_pc)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign mem_en     = mem_en_s;
    assign mem_addr   = pc_r[ADDR_W-1:0];
    assign inst_valid = inst_valid_s;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: a default-depth instance and a DEPTH=4 instance.
module tb_inst_fetch;

    logic        clk, rst;
    logic        start, stop, inst_ready;
    logic        busy, done, mem_en, inst_valid;
    logic [7:0]  mem_addr, inst_pc;
    logic [11:0] mem_inst, inst_out;
    logic        start4, stop4, ready4;
    logic        busy4, done4, mem_en4, valid4;
    logic [7:0]  mem_addr4, inst_pc4;
    logic [11:0] mem_inst4, inst_out4;
    logic [11:0] mem  [0:255];
    logic [11:0] mem4 [0:255];
    logic [3:0]  ctl, ctl4;
    int          checks = 0;
    int          failures = 0;

    assign mem_inst  = mem[mem_addr];
    assign mem_inst4 = mem4[mem_addr4];
    assign ctl       = {busy, done, mem_en, inst_valid};
    assign ctl4      = {busy4, done4, mem_en4, valid4};

    inst_fetch dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_inst(mem_inst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc)
    );

    inst_fetch #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .stop(stop4), .busy(busy4), .done(done4),
        .mem_en(mem_en4), .mem_addr(mem_addr4), .mem_inst(mem_inst4),
        .inst_valid(valid4), .inst_ready(ready4), .inst_out(inst_out4), .inst_pc(inst_pc4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ctl !== 4'b0000 || {inst_out, inst_pc, mem_addr} !== 28'h0) begin
            failures++;
            $display("FAIL reset ctl=%b out=%h pc=%h addr=%h required ctl=0000 all zero", ctl, inst_out, inst_pc, mem_addr);
        end
        checks++;
        if (ctl4 !== 4'b0000 || {inst_out4, inst_pc4, mem_addr4} !== 28'h0) begin
            failures++;
            $display("FAIL reset4 ctl=%b out=%h pc=%h addr=%h required ctl=0000 all zero", ctl4, inst_out4, inst_pc4, mem_addr4);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0]  exp_ctl [6];
        logic [11:0] exp_inst [6];
        logic [7:0]  exp_pc [6];
        exp_ctl  = '{4'b0000, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
        exp_inst = '{12'h000, 12'h000, 12'h101, 12'h202, 12'h000, 12'h000};
        exp_pc   = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
        mem[0] = 12'h101; mem[1] = 12'h202; mem[2] = 12'hFFF;
        inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 start = (c == 0);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL basic_ctl c=%0d got=%b required=%b", c, ctl, exp_ctl[c]);
            end
            if (exp_ctl[c][0]) begin
                checks++;
                if (inst_out !== exp_inst[c] || inst_pc !== exp_pc[c]) begin
                    failures++;
                    $display("FAIL basic_data c=%0d got=%h/%h required=%h/%h", c, inst_out, inst_pc, exp_inst[c], exp_pc[c]);
                end
            end
            if (exp_ctl[c][1]) begin
                checks++;
                if (mem_addr !== 8'(c - 1)) begin
                    failures++;
                    $display("FAIL basic_addr c=%0d got=%h required=%h", c, mem_addr, 8'(c - 1));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_ctl [10];
        int         reads = 0;
        exp_ctl = '{4'b0000, 4'b1010, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                    4'b1011, 4'b1011, 4'b1100, 4'b0000};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 start = (c == 0);
            inst_ready = (c < 2 || c >= 6);
            @(negedge clk);
            if (c < 6 && mem_en) reads++;
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL stall_ctl c=%0d got=%b required=%b", c, ctl, exp_ctl[c]);
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if (inst_out !== 12'h101 || inst_pc !== 8'd0) begin
                    failures++;
                    $display("FAIL stall_hold c=%0d got=%h/%h required=101/00", c, inst_out, inst_pc);
                end
            end
            if (c == 7) begin
                checks++;
                if (inst_out !== 12'h202 || inst_pc !== 8'd1) begin
                    failures++;
                    $display("FAIL stall_next got=%h/%h required=202/01", inst_out, inst_pc);
                end
            end
        end
        checks++;
        if (reads !== 1) begin
            failures++;
            $display("FAIL stall_reads got=%0d required=1", reads);
        end
    endtask

    task automatic test_depth_end();
        logic [3:0] exp_ctl [8];
        int         issues = 0;
        int         bad_reads = 0;
        exp_ctl = '{4'b0000, 4'b1010, 4'b1011, 4'b1011, 4'b1011, 4'b1001, 4'b1100, 4'b0000};
        ready4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 start4 = (c == 0);
            @(negedge clk);
            if (valid4 && ready4) issues++;
            if (mem_en4 && mem_addr4 > 8'd3) bad_reads++;
            checks++;
            if (ctl4 !== exp_ctl[c]) begin
                failures++;
                $display("FAIL depth_ctl c=%0d got=%b required=%b", c, ctl4, exp_ctl[c]);
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (inst_out4 !== 12'(c - 1) || inst_pc4 !== 8'(c - 2)) begin
                    failures++;
                    $display("FAIL depth_data c=%0d got=%h/%h required=%h/%h", c, inst_out4, inst_pc4, 12'(c - 1), 8'(c - 2));
                end
            end
        end
        checks++;
        if (issues !== 4 || bad_reads !== 0) begin
            failures++;
            $display("FAIL depth_count issues=%0d bad_reads=%0d required 4 and 0", issues, bad_reads);
        end
    endtask

    task automatic test_halt_first();
        logic [3:0] exp_ctl [4];
        exp_ctl = '{4'b0000, 4'b1010, 4'b1100, 4'b0000};
        mem[0] = 12'hFFF;
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 start = (c == 0);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL halt0_ctl c=%0d got=%b required=%b", c, ctl, exp_ctl[c]);
            end
        end
    endtask

    task automatic test_stop();
        logic [3:0] exp_ctl [12];
        exp_ctl = '{4'b0000, 4'b1010, 4'b1001, 4'b1001, 4'b0000, 4'b0000,
                    4'b0000, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
        mem[0] = 12'h101; mem[1] = 12'h202; mem[2] = 12'hFFF;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 start = (c == 0 || c == 6);
            stop = (c == 3);
            inst_ready = (c == 3 || c >= 6);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL stop_ctl c=%0d got=%b required=%b", c, ctl, exp_ctl[c]);
            end
            if (c == 7 || c == 8) begin
                checks++;
                if (mem_addr !== 8'(c - 7) || (c == 8 && (inst_out !== 12'h101 || inst_pc !== 8'd0))) begin
                    failures++;
                    $display("FAIL stop_restart c=%0d addr=%h out=%h pc=%h required addr=%h", c, mem_addr, inst_out, inst_pc, 8'(c - 7));
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [3:0] exp_ctl [8];
        exp_ctl = '{4'b0000, 4'b1010, 4'b1001, 4'b1001, 4'b1011, 4'b1001, 4'b0000, 4'b0000};
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 start = (c == 0 || c == 3);
            inst_ready = (c == 4);
            rst = (c == 5);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                failures++;
                $display("FAIL rstmid_ctl c=%0d got=%b required=%b", c, ctl, exp_ctl[c]);
            end
            if (c == 4) begin
                checks++;
                if (inst_out !== 12'h101 || inst_pc !== 8'd0 || mem_addr !== 8'd1) begin
                    failures++;
                    $display("FAIL rstmid_busy_start out=%h pc=%h addr=%h required 101/00/01", inst_out, inst_pc, mem_addr);
                end
            end
            if (c == 6) begin
                checks++;
                if ({inst_out, inst_pc, mem_addr} !== 28'h0) begin
                    failures++;
                    $display("FAIL rstmid_values out=%h pc=%h addr=%h required all zero", inst_out, inst_pc, mem_addr);
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; stop = 1'b0; inst_ready = 1'b0;
        start4 = 1'b0; stop4 = 1'b0; ready4 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 12'h0EE;
            mem4[i] = (i < 4) ? 12'(i + 1) : 12'h0EE;
        end
        test_reset();
        test_basic();
        test_stall();
        test_depth_end();
        test_halt_first();
        test_stop();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
